symm_conv_check: RTL
====================

Name: symm_conv_check

Overview:
- Parametrised successor to the fixed 4x4 symmetric-decorrelation abs stage in the FastICA pipeline.
- Streams one DIM x DIM fixed-point matrix W*W' in row-major order, one element per accepted beat.
- For each element, computes |element - I(r,c)|, then tracks the maximum and the L1 sum of these deviations.
- Issues a per-check converged/done result and keeps an iteration counter with timeout, so the FastICA sequencer can stop iterating.

Parameters:
- DATA_W, 26, element width, signed two's complement.
- FRAC_W, 13, fractional bits; ONE = 1 << FRAC_W (8192 at default).
- DIM, 4, matrix dimension; one check consumes DIM*DIM elements.
- MAX_ITER, 256, number of completed non-converged checks that raises timeout.
- ITER_W, 9, width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk_conv  in  1  clock; all state changes on its rising edge.
- rst_conv  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a check; honoured only in IDLE.
- thresh  in  DATA_W  non-negative convergence threshold (Q FRAC_W), sampled on the accepted start.
- clear_iter  in  1  clears iter_cnt and timeout.
- in_data  in  DATA_W  signed matrix element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data; transfer occurs when in_valid && in_ready.
- busy  out  1  high in ACCUM.
- done  out  1  single-cycle pulse when a check completes.
- converged  out  1  result of the last check; held until the next done.
- max_dev  out  DATA_W  maximum absolute deviation of the last check, non-negative.
- sum_dev  out  DATA_W+2*clog2(DIM)  L1 sum of deviations of the last check.
- iter_cnt  out  ITER_W  completed non-converged checks since the last clear.
- timeout  out  1  sticky; set when iter_cnt reaches MAX_ITER.

Behaviour:
- Reset (async, rst_conv=1): state=IDLE; every output = 0; internal row/col counters, accumulators and the latched threshold = 0.
- FSM states:
  - IDLE: in_ready=0. On start=1, latch thresh, clear row/col and both accumulators, go to ACCUM.
  - ACCUM: in_ready=1, busy=1. Each accepted beat advances col; when col wraps from DIM-1 to 0, row increments. If in_valid is low, counters and accumulators hold. On the beat that accepts element (DIM-1, DIM-1), go to DONE.
  - DONE: lasts one cycle; done=1, in_ready=0, then return to IDLE.
- start received outside IDLE is ignored.
- Deviation, combinational on each accepted beat:
  - d = in_data - ONE when row==col, otherwise in_data; computed in DATA_W+1 bits, so it cannot overflow.
  - a = |d|, saturated to 2^(DATA_W-1)-1.
- Accumulation, registered on the accept edge:
  - max_acc = max(max_acc, a).
  - sum_acc += a; sum_acc is sized so it cannot overflow.
- Result update, on the DONE cycle (same edge that asserts done):
  - max_dev, sum_dev and converged = (max_acc <= latched thresh) become valid together and hold until the next DONE.
- Latency: done asserts exactly one cycle after the final element is accepted. Minimum check time is DIM*DIM+2 cycles from start.
- Iteration counter:
  - On DONE with converged=0, iter_cnt increments, saturating at 2^ITER_W-1.
  - On DONE with converged=1, iter_cnt holds.
  - timeout sets when iter_cnt becomes equal to MAX_ITER and stays set until clear_iter or reset.
  - clear_iter coinciding with DONE: the clear wins; iter_cnt=0 and timeout=0.
- Reset asserted mid-check aborts the check; all outputs return to 0 and no done is produced.

Optional Feature:
- Macro CONV_SUM_EN.
- Defined: the sum accumulator is built and sum_dev reports the L1 sum as described.
- Undefined: the sum accumulator is not synthesised and sum_dev is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- DIM=4, thresh=0, identity stream (diagonal 8192, others 0) -> done one cycle after the 16th accept; max_dev=0, sum_dev=0, converged=1, iter_cnt unchanged.
- Identity except (0,0)=8292 and (1,2)=-300, thresh=200 -> max_dev=300, sum_dev=400 (CONV_SUM_EN defined; 0 when undefined), converged=0, iter_cnt +1.
- Off-diagonal element -33554432 (most negative 26-bit value) -> max_dev=33554431 (saturated), converged=0.
- in_valid toggled 1/0 every cycle plus a second start pulse mid-ACCUM -> second start ignored; results equal the gap-free run; done after 16 accepts.
- MAX_ITER=3, three non-converged checks -> timeout=1 on the third DONE; clear_iter pulse -> iter_cnt=0, timeout=0.
- rst_conv asserted after 7 accepts -> all outputs 0 immediately; a fresh start plus 16 identity elements -> converged=1.

Source files
------------

// File: rtl/symm_conv_check.sv
// Convergence check for FastICA symmetric decorrelation: streams W*W' row-major and reports max/L1 deviation from I.
// Optional macro CONV_SUM_EN builds the L1 sum accumulator; without it sum_dev is tied to zero.
module symm_conv_check #(
  parameter int DATA_W   = 26,
  parameter int FRAC_W   = 13,
  parameter int DIM      = 4,
  parameter int MAX_ITER = 256,
  parameter int ITER_W   = 9
) (
  input  logic                                clk_conv,
  input  logic                                rst_conv,
  input  logic                                start,
  input  logic [DATA_W-1:0]                   thresh,
  input  logic                                clear_iter,
  input  logic signed [DATA_W-1:0]            in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [DATA_W-1:0]                   max_dev,
  output logic [DATA_W+2*$clog2(DIM)-1:0]     sum_dev,
  output logic [ITER_W-1:0]                   iter_cnt,
  output logic                                timeout
);

  localparam int SUM_W = DATA_W + 2*$clog2(DIM);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
  localparam logic signed [DATA_W:0] ONE = (DATA_W+1)'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]              state;
  logic [IDX_W-1:0]        row, col;
  logic [DATA_W-1:0]       thresh_q;
  logic [DATA_W-1:0]       max_acc;

  logic                    vld_p0;
  logic                    last_beat;
  logic signed [DATA_W:0]  dev_p0;
  logic [DATA_W-1:0]       abs_p0;
  logic [DATA_W-1:0]       max_nxt;
  logic                    conv_nxt;
  logic [ITER_W-1:0]       iter_inc;

  // Magnitude of a DATA_W+1 bit deviation, clipped to the largest positive DATA_W value.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W:0] d);
    logic [DATA_W:0] mag;
    mag = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    if (mag > {1'b0, MAX_POS})
      return MAX_POS;
    return mag[DATA_W-1:0];
  endfunction

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state == ST_ACCUM);
  assign done     = (state == ST_DONE);

  // Stage p0: deviation of the accepted element from the identity
  always_comb begin
    vld_p0    = in_valid && in_ready;
    last_beat = vld_p0 && (row == LAST_IDX) && (col == LAST_IDX);
    dev_p0    = {in_data[DATA_W-1], in_data} - ((row == col) ? ONE : '0);
    abs_p0    = sat_abs(dev_p0);
    max_nxt   = (abs_p0 > max_acc) ? abs_p0 : max_acc;
    conv_nxt  = (max_nxt <= thresh_q);
    iter_inc  = (iter_cnt == '1) ? iter_cnt : iter_cnt + 1'b1;
  end

  // Results are written on the final accept edge so they are valid alongside done.
  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      thresh_q  <= '0;
      max_acc   <= '0;
      max_dev   <= '0;
      converged <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            thresh_q <= thresh;
            row      <= '0;
            col      <= '0;
            max_acc  <= '0;
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (vld_p0) begin
            max_acc <= max_nxt;
            if (col == LAST_IDX) begin
              col <= '0;
              row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_beat) begin
              max_dev   <= max_nxt;
              converged <= conv_nxt;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) begin
      iter_cnt <= '0;
      timeout  <= 1'b0;
    end else if (clear_iter) begin
      iter_cnt <= '0;
      timeout  <= 1'b0;
    end else if (last_beat && !conv_nxt) begin
      iter_cnt <= iter_inc;
      if (iter_inc == ITER_W'(MAX_ITER))
        timeout <= 1'b1;
    end
  end

`ifdef CONV_SUM_EN
  logic [SUM_W-1:0] sum_acc;
  logic [SUM_W-1:0] sum_nxt;

  assign sum_nxt = sum_acc + SUM_W'(abs_p0);

  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) begin
      sum_acc <= '0;
      sum_dev <= '0;
    end else if (state == ST_IDLE && start) begin
      sum_acc <= '0;
    end else if (vld_p0) begin
      sum_acc <= sum_nxt;
      if (last_beat)
        sum_dev <= sum_nxt;
    end
  end
`else
  assign sum_dev = '0;
`endif

endmodule
